// File: rtl/mm_entry_array.sv
// mm_entry_array: 20-entry tag-matching operand store. Packets flow S -> S2 -> OUT.
// The external control stage sees FIRE/MF during S and answers with a registered command that is consumed as S2 retires.
module mm_entry_array #(
    parameter int TAG_W  = 8,
    parameter int DATA_W = 16
) (
    input  logic              CP,
    input  logic              MR,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              IN_MF,
    input  logic [TAG_W-1:0]  IN_TAG,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              MF,
    output logic [19:0]       FIRE,
    output logic [19:0]       VALID,
    input  logic [19:0]       EN,
    input  logic              WR_E,
    input  logic              DEL,
    input  logic [5:0]        ADDR,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_PAIR,
    output logic [TAG_W-1:0]  OUT_TAG,
    output logic [DATA_W-1:0] OUT_DATA_L,
    output logic [DATA_W-1:0] OUT_DATA_R,
    output logic              OVF,
    output logic              ERR
);
    localparam int NE = 20;

    logic                      s_v_q, s_mf_q;
    logic [TAG_W-1:0]          s_tag_q;
    logic [DATA_W-1:0]         s_data_q;
    logic                      s2_v_q, s2_mf_q, s2_fire_q;
    logic [NE-1:0]             s2_en_q;
    logic [TAG_W-1:0]          s2_tag_q;
    logic [DATA_W-1:0]         s2_data_q;
    logic [NE-1:0]             valid_q, valid_d;
    logic [NE-1:0][TAG_W-1:0]  tag_q;
    logic [NE-1:0][DATA_W-1:0] data_q;
    logic                      out_v_q, out_v_d, out_pair_q;
    logic [TAG_W-1:0]          out_tag_q;
    logic [DATA_W-1:0]         out_l_q, out_r_q;
    logic                      ovf_q, err_q;
    logic                      accept, addr_ok;
    logic [4:0]                a;
    logic                      do_out, do_del, do_wr, do_ovf, do_err;

    assign IN_READY   = !s_v_q && !s2_v_q && !out_v_q;
    assign accept     = IN_VALID && IN_READY;
    assign MF         = s_v_q && s_mf_q;
    assign VALID      = valid_q;
    assign OUT_VALID  = out_v_q;
    assign OUT_PAIR   = out_pair_q;
    assign OUT_TAG    = out_tag_q;
    assign OUT_DATA_L = out_l_q;
    assign OUT_DATA_R = out_r_q;
    assign OVF        = ovf_q;
    assign ERR        = err_q;

    for (genvar i = 0; i < NE; i++) begin : g_fire
        assign FIRE[i] = MF && valid_q[i] && (tag_q[i] == s_tag_q);
    end

    // Retirement decision; any command that disagrees with local state is refused wholesale.
    always_comb begin
        addr_ok = (ADDR < 6'd20);
        a       = addr_ok ? ADDR[4:0] : 5'd0;
        do_out  = 1'b0;
        do_del  = 1'b0;
        do_wr   = 1'b0;
        do_ovf  = 1'b0;
        do_err  = 1'b0;
        if (s2_v_q) begin
            if (!s2_mf_q) begin
                do_out = 1'b1;
            end else if (s2_fire_q) begin
                if (DEL && addr_ok && valid_q[a] && (tag_q[a] == s2_tag_q)) begin
                    do_out = 1'b1;
                    do_del = 1'b1;
                end else begin
                    do_err = 1'b1;
                end
            end else if (s2_en_q == '0) begin
                do_ovf = 1'b1;
            end else if (WR_E && addr_ok && s2_en_q[a]) begin
                do_wr = 1'b1;
            end else begin
                do_err = 1'b1;
            end
        end

        valid_d = valid_q;
        if (do_del) valid_d[a] = 1'b0;
        if (do_wr)  valid_d[a] = 1'b1;

        out_v_d = out_v_q;
        if (do_out)                    out_v_d = 1'b1;
        else if (out_v_q && OUT_READY) out_v_d = 1'b0;
    end

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            s_v_q     <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_mf_q   <= 1'b0;
            s2_fire_q <= 1'b0;
            s2_en_q   <= '0;
            valid_q   <= '0;
            out_v_q   <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            s_v_q   <= accept;
            s2_v_q  <= s_v_q;
            if (s_v_q) begin
                s2_mf_q   <= s_mf_q;
                s2_fire_q <= |FIRE;
                s2_en_q   <= EN;
            end
            valid_q <= valid_d;
            out_v_q <= out_v_d;
            if (do_ovf) ovf_q <= 1'b1;
            if (do_err) err_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: every consumer is qualified by a reset valid bit.
    always_ff @(posedge CP) begin
        if (accept) begin
            s_mf_q   <= IN_MF;
            s_tag_q  <= IN_TAG;
            s_data_q <= IN_DATA;
        end
        if (s_v_q) begin
            s2_tag_q  <= s_tag_q;
            s2_data_q <= s_data_q;
        end
        if (do_wr) begin
            tag_q[a]  <= s2_tag_q;
            data_q[a] <= s2_data_q;
        end
        if (do_out) begin
            out_pair_q <= s2_mf_q;
            out_tag_q  <= s2_tag_q;
            out_l_q    <= do_del ? data_q[a] : '0;
            out_r_q    <= s2_data_q;
        end
    end
endmodule

// File: tb/tb_mm_entry_array.sv
// Bench for mm_entry_array: plays the control stage from a set-level model of the entry array.
module tb_mm_entry_array;
    logic        cp, mr, in_valid, in_ready, in_mf, mf_o, wr_e, del, out_valid, out_ready;
    logic        out_pair, ovf, err;
    logic [7:0]  in_tag, out_tag;
    logic [15:0] in_data, out_data_l, out_data_r;
    logic [19:0] fire, valid, en;
    logic [5:0]  addr;

    int checks = 0;
    int errors = 0;

    bit          m_v [20];
    logic [7:0]  m_t [20];
    logic [15:0] m_d [20];
    bit          m_ovf, m_err;

    mm_entry_array #(.TAG_W(8), .DATA_W(16)) dut (
        .CP(cp), .MR(mr), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_MF(in_mf),
        .IN_TAG(in_tag), .IN_DATA(in_data), .MF(mf_o), .FIRE(fire), .VALID(valid),
        .EN(en), .WR_E(wr_e), .DEL(del), .ADDR(addr), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OUT_PAIR(out_pair), .OUT_TAG(out_tag),
        .OUT_DATA_L(out_data_l), .OUT_DATA_R(out_data_r), .OVF(ovf), .ERR(err)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] model_vec();
        logic [19:0] v = '0;
        for (int i = 0; i < 20; i++) v[i] = m_v[i];
        return v;
    endfunction

    task automatic do_reset();
        wr_e = 1'b0; del = 1'b1; addr = '0; en = '0; in_valid = 1'b0; out_ready = 1'b1;
        mr = 1'b0;
        #3;
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        @(negedge cp);
        mr = 1'b1;
        for (int i = 0; i < 20; i++) m_v[i] = 1'b0;
        m_ovf = 1'b0; m_err = 1'b0;
        @(negedge cp);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
    endtask

    // One packet through the pipe; control command derived from the model, outputs checked against it.
    task automatic xact(input logic mf, input logic [7:0] tag, input logic [15:0] dat,
                        input bit bad, input int hold,
                        output logic ov, output logic op, output logic [15:0] ol,
                        output logic [19:0] ovld);
        logic [19:0] mv;
        int hit, fr, n;
        bit e_out, e_pair;
        logic [15:0] e_l, s_l, s_r;
        @(negedge cp);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge cp); n++; end
        chk("in_ready_wait", 64'(in_ready), 64'(1));
        mv = '0; hit = -1; fr = -1;
        for (int i = 0; i < 20; i++) begin
            if (m_v[i] && m_t[i] == tag) begin mv[i] = 1'b1; if (hit < 0) hit = i; end
            if (!m_v[i] && fr < 0) fr = i;
        end
        en = (fr >= 0) ? (20'd1 << fr) : 20'd0;
        in_valid = 1'b1; in_mf = mf; in_tag = tag; in_data = dat;
        @(posedge cp); #1;
        in_valid = 1'b0; in_mf = 1'($urandom); in_tag = 8'($urandom); in_data = 16'($urandom);
        @(negedge cp);
        chk("mf", 64'(mf_o), 64'(mf));
        chk("fire", 64'(fire), 64'(mf ? mv : 20'd0));
        chk("ready_busy", 64'(in_ready), 64'(0));
        @(posedge cp); #1;
        en = 20'($urandom);
        if (!mf)           begin wr_e = 1'b0; del = 1'b1; addr = 6'($urandom_range(0, 19)); end
        else if (hit >= 0) begin wr_e = 1'b0; del = 1'b1; addr = bad ? 6'd25 : 6'(hit); end
        else if (fr >= 0)  begin wr_e = 1'b1; del = 1'b0; addr = 6'(fr); end
        else               begin wr_e = 1'b0; del = 1'b1; addr = '0; end
        out_ready = (hold == 0);
        @(posedge cp); #1;
        wr_e = 1'($urandom); del = 1'b1; addr = 6'($urandom_range(0, 19));
        e_out = 0; e_pair = 0; e_l = '0;
        if (mf && bad)     m_err = 1'b1;
        else if (!mf)      e_out = 1;
        else if (hit >= 0) begin e_out = 1; e_pair = 1; e_l = m_d[hit]; m_v[hit] = 1'b0; end
        else if (fr >= 0)  begin m_v[fr] = 1'b1; m_t[fr] = tag; m_d[fr] = dat; end
        else               m_ovf = 1'b1;
        @(negedge cp);
        ov = out_valid; op = out_pair; ol = out_data_l; ovld = valid;
        chk("out_valid", 64'(out_valid), 64'(e_out));
        chk("valid_vec", 64'(valid), 64'(model_vec()));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("err", 64'(err), 64'(m_err));
        if (e_out) begin
            chk("out_pair", 64'(out_pair), 64'(e_pair));
            chk("out_tag", 64'(out_tag), 64'(tag));
            chk("out_l", 64'(out_data_l), 64'(e_l));
            chk("out_r", 64'(out_data_r), 64'(dat));
            s_l = out_data_l; s_r = out_data_r;
            for (int k = 0; k < hold; k++) begin
                @(negedge cp);
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_payload", 64'({out_data_l, out_data_r}), 64'({s_l, s_r}));
                chk("hold_ready", 64'(in_ready), 64'(0));
            end
            out_ready = 1'b1;
            @(negedge cp);
            chk("drain_valid", 64'(out_valid), 64'(0));
        end
        out_ready = 1'b1;
        chk("ready_idle", 64'(in_ready), 64'(1));
    endtask

    typedef struct {
        logic        mf;
        logic [7:0]  tag;
        logic [15:0] dat;
        logic        e_ov;
        logic        e_pair;
        logic [15:0] e_l;
        logic [19:0] e_valid;
    } vec_t;

    vec_t vecs[7];
    logic        ov, op;
    logic [15:0] ol;
    logic [19:0] ovld;

    initial begin
        vecs[0] = '{1'b1, 8'h12, 16'h00AA, 1'b0, 1'b0, 16'h0000, 20'h00001};
        vecs[1] = '{1'b1, 8'h12, 16'h0055, 1'b1, 1'b1, 16'h00AA, 20'h00000};
        vecs[2] = '{1'b0, 8'h07, 16'h1234, 1'b1, 1'b0, 16'h0000, 20'h00000};
        vecs[3] = '{1'b1, 8'h30, 16'h0001, 1'b0, 1'b0, 16'h0000, 20'h00001};
        vecs[4] = '{1'b1, 8'h31, 16'h0002, 1'b0, 1'b0, 16'h0000, 20'h00003};
        vecs[5] = '{1'b1, 8'h30, 16'h0003, 1'b1, 1'b1, 16'h0001, 20'h00002};
        vecs[6] = '{1'b1, 8'h31, 16'h0004, 1'b1, 1'b1, 16'h0002, 20'h00000};
        in_mf = 1'b0; in_tag = '0; in_data = '0;
        do_reset();

        for (int v = 0; v < 7; v++) begin
            xact(vecs[v].mf, vecs[v].tag, vecs[v].dat, 1'b0, 0, ov, op, ol, ovld);
            chk("tbl_ov", 64'(ov), 64'(vecs[v].e_ov));
            if (vecs[v].e_ov) begin
                chk("tbl_pair", 64'(op), 64'(vecs[v].e_pair));
                chk("tbl_l", 64'(ol), 64'(vecs[v].e_l));
            end
            chk("tbl_valid", 64'(ovld), 64'(vecs[v].e_valid));
        end

        // Backpressure on a bypass result.
        xact(1'b0, 8'h07, 16'hBEEF, 1'b0, 10, ov, op, ol, ovld);

        // Fill all entries, then overflow with a fresh tag, then match one back out.
        for (int i = 0; i < 20; i++) xact(1'b1, 8'(8'h80 + i), 16'(16'h1000 + i), 1'b0, 0, ov, op, ol, ovld);
        chk("full_valid", 64'(valid), 64'(20'hFFFFF));
        xact(1'b1, 8'hF0, 16'h5A5A, 1'b0, 0, ov, op, ol, ovld);
        chk("full_ovf", 64'(ovf), 64'(1));
        chk("full_no_out", 64'(ov), 64'(0));
        xact(1'b1, 8'h85, 16'h7777, 1'b0, 0, ov, op, ol, ovld);
        chk("full_match_l", 64'(ol), 64'(16'h1005));

        // Bad delete address on a fired packet.
        do_reset();
        xact(1'b1, 8'h55, 16'h0101, 1'b0, 0, ov, op, ol, ovld);
        xact(1'b1, 8'h55, 16'h0202, 1'b1, 0, ov, op, ol, ovld);
        chk("bad_err", 64'(err), 64'(1));
        chk("bad_valid", 64'(valid), 64'(20'h00001));

        // Reset while a matching packet is in flight.
        do_reset();
        xact(1'b1, 8'h66, 16'h0303, 1'b0, 0, ov, op, ol, ovld);
        @(negedge cp);
        in_valid = 1'b1; in_mf = 1'b1; in_tag = 8'h66; in_data = 16'h0404;
        @(posedge cp); #1;
        in_valid = 1'b0; wr_e = 1'b0; del = 1'b1;
        #2 mr = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(valid), 64'(0));
        chk("mid_rst_out", 64'(out_valid), 64'(0));
        @(negedge cp);
        mr = 1'b1;
        for (int i = 0; i < 20; i++) m_v[i] = 1'b0;
        m_ovf = 1'b0; m_err = 1'b0;
        repeat (4) @(negedge cp);
        chk("mid_rst_no_out", 64'(out_valid), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(1));

        // Randomised traffic against the model.
        do_reset();
        for (int r = 0; r < 200; r++) begin
            xact(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 23)), 16'($urandom), 1'b0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0, ov, op, ol, ovld);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mm_entry_array.md
MM_ENTRY_ARRAY -- requirements
Module: mm_entry_array

Interface
REQ-001 SHALL have parameter TAG_W, default 8: packet tag (match key) width.
REQ-002 SHALL have parameter DATA_W, default 16: packet operand width; entry count fixed at 20.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
- CP  in  1  clock; all state updates on its rising edge.
- MR  in  1  asynchronous active-low reset.
- IN_VALID  in  1  incoming packet strobe.
- IN_READY  out  1  packet accepted when IN_VALID && IN_READY at a CP edge.
- IN_MF  in  1  packet requires matching (1) or bypasses (0).
- IN_TAG  in  TAG_W  match key.
- IN_DATA  in  DATA_W  operand.
- MF  out  1  to control stage: S_v && S_mf.
- FIRE  out  20  to control stage: bit i = S_v && S_mf && VALID[i] && tag[i]==S_tag.
- VALID  out  20  entry occupancy.
- EN  in  20  one-hot free-entry enable from control stage.
- WR_E  in  1  registered write command from control stage.
- DEL  in  1  registered delete/read command from control stage.
- ADDR  in  6  registered entry address from control stage.
- OUT_VALID  out  1  result packet valid.
- OUT_READY  in  1  downstream accepts result.
- OUT_PAIR  out  1  1 = matched pair, 0 = bypass.
- OUT_TAG  out  TAG_W  result tag.
- OUT_DATA_L  out  DATA_W  stored operand (0 on bypass).
- OUT_DATA_R  out  DATA_W  incoming operand.
- OVF  out  1  sticky: matching packet dropped, no free entry.
- ERR  out  1  sticky: control command inconsistent with local state.

Function
REQ-004 SHALL hold a 3-deep pipeline: S (accept), S2 (action), OUT (result register).
REQ-005 SHALL drive IN_READY = !S_v && !S2_v && !OUT_VALID; max one packet per 3 cycles.
REQ-006 On accept at edge N: S loads {IN_TAG, IN_DATA, IN_MF}, S_v=1.
REQ-007 At edge N+1: S moves to S2; S2 also captures FIRE_OR=|FIRE and EN; S_v=0.
REQ-008 At edge N+2 (control outputs valid), S2 retires, exactly one action:
- S2_mf=0: OUT <= {PAIR=0, S2 tag, L=0, R=S2 data}; entries untouched.
- S2_mf=1, fired, DEL=1: OUT <= {PAIR=1, S2 tag, L=data[ADDR], R=S2 data}; VALID[ADDR] cleared.
- S2_mf=1, not fired, WR_E=1, EN_q!=0: entry[ADDR] <= {S2 tag, S2 data}; VALID[ADDR] set; no output.
- S2_mf=1, not fired, EN_q==0: packet dropped, OVF set.
REQ-009 Write/delete SHALL act only under REQ-008; WR_E/DEL outside S2 retirement ignored (DEL idles high).
REQ-010 ERR SHALL set if at retirement: ADDR>19; write with EN_q[ADDR]==0 but EN_q!=0; delete with VALID[ADDR]==0 or tag[ADDR]!=S2 tag; mf=1 and neither WR_E nor DEL. On ERR, no entry is modified and no output is produced.
REQ-011 OUT_VALID SHALL hold, with stable payload, until OUT_VALID && OUT_READY; then clears.
REQ-012 Multiple FIRE bits possible (duplicate tags); consumed entry is the one named by ADDR (lowest-index by control stage).
REQ-013 Latency accept-to-OUT_VALID: 2 edges (OUT_VALID high after edge N+2); entry write visible in VALID after edge N+2.
REQ-014 FIRE, VALID, MF SHALL be combinational from registered state only (no IN_* path).

Reset
REQ-015 MR low SHALL asynchronously clear S_v, S2_v, OUT_VALID, all VALID bits, OVF, ERR; IN_READY=1 after release; entry tag/data need not be reset.
REQ-016 MR low mid-operation SHALL discard in-flight packet and all stored entries; no output produced.

Verification
REQ-017 Reset: MR low then high -> VALID=0, OUT_VALID=0, IN_READY=1, OVF=0, ERR=0.
REQ-018 Store then match: tag 0x12 data 0x00AA (MF=1) -> VALID[0]=1 after 2 edges; tag 0x12 data 0x0055 -> OUT {PAIR=1, TAG=0x12, L=0x00AA, R=0x0055}, VALID[0]=0.
REQ-019 Bypass: MF=0 tag 0x07 data 0x1234 -> OUT {PAIR=0, L=0, R=0x1234} 2 edges after accept; VALID unchanged.
REQ-020 Full: 20 distinct tags stored, 21st distinct tag -> OVF=1, VALID stays all ones, no output.
REQ-021 Backpressure: OUT_READY=0 for 10 cycles after a result -> payload stable, IN_READY=0 throughout; OUT_READY=1 -> OUT_VALID clears next edge, IN_READY=1.
REQ-022 Bad command: force DEL with ADDR=25 on a fired packet -> ERR=1, VALID unchanged, OUT_VALID=0.
